// File: rtl/add8s_seq.sv
// Bit-serial 8-bit adder: sum = A + B + C_we, one bit per clock, LSB first.
// Nine-bit result is registered and held until the next completed addition.
module add8s_seq (
    input  logic CLK,
    input  logic RST,
    input  logic START,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic A4,
    input  logic A5,
    input  logic A6,
    input  logic A7,
    input  logic A8,
    input  logic B1,
    input  logic B2,
    input  logic B3,
    input  logic B4,
    input  logic B5,
    input  logic B6,
    input  logic B7,
    input  logic B8,
    input  logic C_we,
    output logic out1,
    output logic out2,
    output logic out3,
    output logic out4,
    output logic out5,
    output logic out6,
    output logic out7,
    output logic out8,
    output logic C_wy,
    output logic BUSY,
    output logic DONE
);

    // state | meaning
    // IDLE  | waiting for START; operands latched on the accepting edge
    // RUN   | one full-add per edge, bits 1..8
    // FIN   | result just loaded; DONE pulse
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] w_a;
    logic [7:0] w_b;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [2:0] r_cnt;
    logic       r_carry;
    logic [6:0] r_sum;
    logic [7:0] r_out;
    logic       r_cout;
    logic       w_s;
    logic       w_c;

    assign w_a = {A8, A7, A6, A5, A4, A3, A2, A1};
    assign w_b = {B8, B7, B6, B5, B4, B3, B2, B1};

    assign w_s = r_a[r_cnt] ^ r_b[r_cnt] ^ r_carry;
    assign w_c = (r_a[r_cnt] & r_b[r_cnt]) | (r_carry & (r_a[r_cnt] ^ r_b[r_cnt]));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        BUSY   = 1'b0;
        DONE   = 1'b0;
        case (r_state)
            IDLE: begin
                if (START) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                BUSY = 1'b1;
                if (r_cnt == 3'd7) begin
                    w_next = FIN;
                end
            end
            FIN: begin
                BUSY   = 1'b1;
                DONE   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Sum bits shift in from the top; on the last edge the seven stored bits
    // plus the current sum bit form the complete low byte.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_cnt   <= 3'd0;
            r_carry <= 1'b0;
            r_sum   <= 7'h00;
            r_out   <= 8'h00;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_a     <= w_a;
                        r_b     <= w_b;
                        r_carry <= C_we;
                        r_cnt   <= 3'd0;
                    end
                end
                RUN: begin
                    r_sum   <= {w_s, r_sum[6:1]};
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_out  <= {w_s, r_sum};
                        r_cout <= w_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out1 = r_out[0];
    assign out2 = r_out[1];
    assign out3 = r_out[2];
    assign out4 = r_out[3];
    assign out5 = r_out[4];
    assign out6 = r_out[5];
    assign out7 = r_out[6];
    assign out8 = r_out[7];
    assign C_wy = r_cout;

endmodule

// File: tb/tb_add8s_seq.sv
// Self-checking bench for add8s_seq: cycle model + result scoreboard plus directed cases.
module tb_add8s_seq;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       START = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       cin = 1'b0;
    logic [7:0] out;
    logic       C_wy, BUSY, DONE;

    int n_chk  = 0;
    int n_pass = 0;

    logic [8:0] sb_q[$];
    int         m_cnt = 0;
    logic [8:0] m_res = 9'h000;
    bit         chk_en = 1'b0;
    int         cyc = 0;

    add8s_seq u_dut (
        .CLK(CLK), .RST(RST), .START(START),
        .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]),
        .A5(a[4]), .A6(a[5]), .A7(a[6]), .A8(a[7]),
        .B1(b[0]), .B2(b[1]), .B3(b[2]), .B4(b[3]),
        .B5(b[4]), .B6(b[5]), .B7(b[6]), .B8(b[7]),
        .C_we(cin),
        .out1(out[0]), .out2(out[1]), .out3(out[2]), .out4(out[3]),
        .out5(out[4]), .out6(out[5]), .out7(out[6]), .out8(out[7]),
        .C_wy(C_wy), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk_eq(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%03h expected 0x%03h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Timing model: 9 busy cycles after an accepted START; the expected sum is
    // computed arithmetically from the operands present on the accepting edge.
    always @(posedge CLK) begin
        cyc++;
        if (!RST) begin
            m_cnt = 0;
            m_res = 9'h000;
            sb_q.delete();
        end else if (m_cnt == 0) begin
            if (START) begin
                m_cnt = 9;
                sb_q.push_back({1'b0, a} + {1'b0, b} + {8'h00, cin});
            end
        end else begin
            m_cnt = m_cnt - 1;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            if (m_cnt == 1) begin
                if (sb_q.size() > 0) m_res = sb_q.pop_front();
                else chk_eq("sb_empty", 9'd0, 9'd1);
            end
            chk_eq("busy", {8'h00, BUSY}, {8'h00, (m_cnt != 0)});
            chk_eq("done", {8'h00, DONE}, {8'h00, (m_cnt == 1)});
            chk_eq("result", {C_wy, out}, m_res);
        end
    end

    task automatic run_add(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                           input logic ic, input logic [8:0] exp);
        int lat;
        bit seen;
        a = ia; b = ib; cin = ic; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        a = 8'h00; b = 8'h00; cin = 1'b0;
        lat = 1;
        seen = 1'b0;
        while (!seen && lat < 30) begin
            if (DONE) seen = 1'b1;
            else begin
                @(negedge CLK);
                lat++;
            end
        end
        chk_eq({tag, "_seen"}, {8'h00, seen}, 9'd1);
        chk_eq({tag, "_lat"}, lat[8:0], 9'd9);
        chk_eq(tag, {C_wy, out}, exp);
        @(negedge CLK);
    endtask

    initial begin
        int d_cnt;
        int d_cyc[$];

        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk_eq("rst_out", {C_wy, out}, 9'h000);
        chk_eq("rst_busy", {7'h00, BUSY, DONE}, 9'h000);
        RST = 1'b1;
        chk_en = 1'b1;
        @(negedge CLK);

        run_add("zero", 8'h00, 8'h00, 1'b0, 9'h000);
        run_add("ff_p1", 8'hFF, 8'h01, 1'b0, 9'h100);
        run_add("5a_a5_c", 8'h5A, 8'hA5, 1'b1, 9'h100);
        run_add("sub_rt", 8'hDD, 8'h5F, 1'b0, 9'h13C);
        run_add("mix", 8'h37, 8'h49, 1'b1, 9'h081);
        run_add("prev12", 8'h10, 8'h02, 1'b0, 9'h012);

        // Inputs and START toggling during RUN must not disturb the latched add.
        a = 8'h01; b = 8'h02; cin = 1'b0; START = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk_eq("hold12", {C_wy, out}, 9'h012);
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); START = 1'b1;
        end
        @(negedge CLK);
        START = 1'b0;
        chk_eq("ign_done", {8'h00, DONE}, 9'd1);
        chk_eq("ign_res", {C_wy, out}, 9'h003);
        repeat (2) @(negedge CLK);

        // Reset in the middle of RUN aborts with cleared outputs.
        a = 8'h77; b = 8'h11; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        chk_eq("abort_out", {C_wy, out}, 9'h000);
        chk_eq("abort_flags", {7'h00, BUSY, DONE}, 9'h000);
        repeat (12) @(negedge CLK);
        run_add("post_rst", 8'h80, 8'h80, 1'b0, 9'h100);

        // START held high: one addition every 10 cycles.
        d_cnt = 0;
        a = 8'h21; b = 8'h43; cin = 1'b0; START = 1'b1;
        for (int i = 1; i < 30; i++) begin
            @(negedge CLK);
            if (DONE) begin
                d_cnt++;
                d_cyc.push_back(i);
            end
        end
        START = 1'b0;
        chk_eq("held_pulses", d_cnt[8:0], 9'd3);
        if (d_cyc.size() == 3) begin
            chk_eq("held_first", d_cyc[0][8:0], 9'd9);
            chk_eq("held_gap1", 9'(d_cyc[1] - d_cyc[0]), 9'd10);
            chk_eq("held_gap2", 9'(d_cyc[2] - d_cyc[1]), 9'd10);
        end
        chk_eq("held_res", {C_wy, out}, 9'h064);
        repeat (3) @(negedge CLK);
        chk_eq("sb_drain", sb_q.size() > 0 ? 9'd1 : 9'd0, 9'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/add8s_seq.md
ADD8S_SEQ -- requirements
Module: add8s_seq

Interface
REQ-001 Parameters: none; the operand width is fixed at 8 bits, bit 1 is the LSB and bit 8 the MSB.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 CLK  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-004 RST  input  1  synchronous reset, active low, sampled on the rising edge of CLK.
REQ-005 START  input  1  request; sampled only in IDLE.
REQ-006 A1..A8  input  1 each  augend bits; A1 is the LSB.
REQ-007 B1..B8  input  1 each  addend bits; B1 is the LSB.
REQ-008 C_we  input  1  carry-in to bit 1.
REQ-009 out1..out8  output  1 each  registered sum bits; out1 is the LSB.
REQ-010 C_wy  output  1  registered carry-out of bit 8.
REQ-011 BUSY  output  1  high while an addition is in progress (RUN or FIN).
REQ-012 DONE  output  1  one-cycle pulse; result is valid and newly loaded.

Function
REQ-013 The block SHALL be the bit-serial counterpart of the team's 8-bit borrow-ripple subtractor: sum = A + B + C_we.
REQ-014 Result width SHALL be 9 bits: out8..out1 hold the low 8 bits and C_wy holds bit 9.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and FIN.
REQ-016 IDLE to RUN: on an edge with RST=1 and START=1, the block SHALL latch A, B and C_we into internal registers, set bit counter=0 and set carry register=C_we.
REQ-017 In RUN, each edge SHALL perform a full-add of A[cnt+1], B[cnt+1] and the carry into sum-shift bit cnt+1, update the carry, and increment cnt.
REQ-018 RUN to FIN: on the edge that processes cnt=7; that same edge SHALL copy the sum-shift register to out1..out8 and the final carry to C_wy.
REQ-019 FIN to IDLE: unconditionally after one cycle.
REQ-020 DONE SHALL be 1 only in FIN; BUSY SHALL be 1 in RUN and FIN.
REQ-021 Latency: START sampled at edge k gives RUN during cycles k+1..k+8, DONE high during cycle k+9 and IDLE again at cycle k+10; this is a fixed 9-cycle latency.
REQ-022 out1..out8 and C_wy SHALL hold the previous result through RUN and change only on the RUN to FIN edge.
REQ-023 START SHALL be ignored in RUN and FIN; it is not queued.
REQ-024 A, B and C_we SHALL be ignored after the latch edge; changes during RUN SHALL NOT affect the result.
REQ-025 START held high continuously SHALL start a new addition every 10 cycles.
REQ-026 Overflow wraps: out keeps the low 8 bits and C_wy=1; no other flag is produced.

Reset
REQ-027 An edge with RST=0 SHALL force IDLE, cnt=0, carry=0 and clear all internal registers.
REQ-028 That same edge SHALL set out1..out8=0, C_wy=0, BUSY=0 and DONE=0.
REQ-029 Reset SHALL take priority over START and over any RUN or FIN activity.
REQ-030 Reset mid-RUN SHALL abort the addition with no DONE pulse and SHALL leave outputs cleared to 0, not partially updated.
REQ-031 After reset is released, the first START SHALL behave exactly as in REQ-016.

Verification
REQ-032 Reset, then A=0x00, B=0x00, C_we=0, START pulse -> DONE at cycle 9, out=0x00, C_wy=0, BUSY high for exactly 9 cycles.
REQ-033 A=0xFF, B=0x01, C_we=0 -> out=0x00, C_wy=1; A=0x5A, B=0xA5, C_we=1 -> out=0x00, C_wy=1.
REQ-034 Subtractor round-trip: the subtractor gives 0x3C-0x5F = diff 0xDD with borrow 1; feed A=0xDD, B=0x5F, C_we=0 -> out=0x3C, C_wy=1.
REQ-035 Latch the previous result 0x12; START with A=0x01, B=0x02; toggle A and B and pulse START every cycle during RUN -> out stays 0x12 until the FIN edge, then becomes 0x03 with a single DONE pulse.
REQ-036 RST=0 at RUN cycle 4 -> next cycle outputs all 0, BUSY=0, no DONE; a subsequent START with A=0x80, B=0x80 -> out=0x00, C_wy=1.
REQ-037 START held high for 30 cycles -> exactly 3 DONE pulses, 10 cycles apart.
